sram_array_ctrl: RTL and testbench
==================================

Name: sram_array_ctrl

Overview:
Access controller that sits directly upstream of a single-port, 1-cycle-read-latency, bit-masked SRAM macro (128 x 216 default). It turns independent write and read valid/ready request channels into one macro operation per cycle. It captures read data into a small response FIFO so the consumer can apply backpressure. After reset it zero-fills the array before accepting traffic.

Parameters:
SETS, 128, number of entries; must be a power of two
WIDTH, 216, data and mask width in bits
ADDR_W, 7, address width, equal to log2(SETS)
INIT_EN, 1, 1 = zero-fill the array after reset; 0 = go straight to RUN
RESP_DEPTH, 2, response FIFO entries (minimum 2)

Ports:
clock  in  1  single clock for the block and the macro
reset  in  1  asynchronous, active-low reset
w_valid  in  1  write request valid
w_ready  out  1  write request accepted when high with w_valid
w_addr  in  ADDR_W  write address
w_data  in  WIDTH  write data
w_mask  in  WIDTH  per-bit write enable
r_valid  in  1  read request valid
r_ready  out  1  read request accepted when high with r_valid
r_addr  in  ADDR_W  read address
resp_valid  out  1  read response valid
resp_ready  in  1  consumer accepts the response
resp_data  out  WIDTH  read response data
init_done  out  1  high once the zero-fill is complete
sram_addr  out  ADDR_W  to macro RW0_addr
sram_en  out  1  to macro RW0_en
sram_wmode  out  1  to macro RW0_wmode (1 = write)
sram_wmask  out  WIDTH  to macro RW0_wmask
sram_wdata  out  WIDTH  to macro RW0_wdata
sram_rdata  in  WIDTH  from macro RW0_rdata

Behaviour:
- Reset (reset low, asynchronous) forces the following, and all are held while reset is low:
  - state = INIT if INIT_EN, else RUN
  - init counter = 0, priority bit = write-first
  - FIFO empty, in-flight flag = 0
  - outputs: w_ready = 0, r_ready = 0, resp_valid = 0, init_done = 0, sram_en = 0, resp_data = 0
- INIT state:
  - Each cycle drives sram_en = 1, sram_wmode = 1, sram_wmask = all ones, sram_wdata = 0, sram_addr = counter.
  - Counter increments by 1 per cycle, starting from 0.
  - After the cycle with counter = SETS-1, the state moves to RUN and init_done rises the following cycle. SETS cycles total.
  - w_ready = r_ready = 0 throughout INIT.
- RUN state (init_done = 1, sticky until reset):
  - Exactly one macro operation per cycle.
  - Write eligible: w_valid.
  - Read eligible: r_valid and credit_ok, where credit_ok = (fifo_count + inflight - (resp_valid and resp_ready)) < RESP_DEPTH. r_ready therefore depends combinationally on resp_ready.
  - Both eligible: grant follows the priority bit; the bit flips after every conflicted grant.
  - Only one eligible: grant it; the priority bit is unchanged.
  - The losing request sees ready = 0.
- Granted write: sram_en = 1, sram_wmode = 1, and addr/mask/data pass through unchanged. Masking is performed in the macro.
- Granted read at cycle T:
  - sram_en = 1, sram_wmode = 0; inflight = 1 during T+1.
  - sram_rdata is pushed into the FIFO at the end of T+1.
  - resp_valid is high from T+2. Minimum read latency is 2 cycles.
- No grant: sram_en = 0. sram_wdata/wmask are don't-care when not writing and are driven 0.
- Ordering:
  - Write at T, read of the same address at T+1 or later returns the new data.
  - Read at T, write of the same address at T+1 returns the old data, because capture happens before the write lands.
- FIFO: in-order, with simultaneous push and pop allowed. The credit rule guarantees a push never finds it full; an overflow is an assertion failure.
- Back-to-back reads with resp_ready held high sustain one read per cycle.
- Reset asserted mid-operation: in-flight reads and FIFO contents are discarded and no response is produced. After release the block re-enters INIT.

Decomposition:
- Package sram_ctrl_pkg: SETS, WIDTH, ADDR_W defaults and the state enum {INIT, RUN}.
- One sub-module: sram_resp_fifo, parameterised WIDTH and RESP_DEPTH. It provides push, pop, count, and an asynchronous active-low reset.

Test Plan:
1. Release reset (INIT_EN=1) -> exactly 128 write cycles with addr 0..127, data 0 and mask all ones; init_done = 1 at cycle 129. A read of addr 5 then returns 0.
2. Write addr 3 with data 0xA5 repeated and mask all ones; read addr 3 next cycle -> resp_valid two cycles after the read grant, resp_data = 0xA5 repeated.
3. Write addr 9 all ones; write addr 9 data 0 with mask = 0xFF (low byte); read -> resp_data = all ones except low byte = 0x00.
4. w_valid and r_valid both held for 4 cycles, resp_ready = 1 -> grant sequence W, R, W, R; a write-only request afterward leaves the priority unchanged.
5. resp_ready = 0 with r_valid held -> exactly 2 reads accepted, then r_ready = 0. Raising resp_ready -> responses pop in issue order and reads resume at 1 per cycle.
6. Read addr 7 (value 0x11) at T, write addr 7 = 0x22 at T+1 -> response 0x11; a subsequent read -> 0x22. Then assert reset with 2 responses pending -> resp_valid drops immediately, no stale responses after release, and INIT reruns.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM array controller.
// Holds the default array geometry and the controller state encoding.
package sram_ctrl_pkg;

  localparam int SETS_DEFAULT   = 128;
  localparam int WIDTH_DEFAULT  = 216;
  localparam int ADDR_W_DEFAULT = 7;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order response FIFO holding read data until the consumer takes it.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_push, i_push_data enqueue one entry
//   i_pop               dequeue the head entry
//   o_head              current head entry (valid when o_count != 0)
//   o_count             number of stored entries
module sram_resp_fifo #(
  parameter int WIDTH      = 216,
  parameter int RESP_DEPTH = 2,
  localparam int CNT_W     = $clog2(RESP_DEPTH + 1),
  localparam int PTR_W     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [RESP_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  // Pointer advance with wrap, so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RESP_DEPTH - 1)) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  assign w_full  = (r_count == CNT_W'(RESP_DEPTH));
  assign w_pop   = i_pop & (r_count != {CNT_W{1'b0}});
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Data storage; contents are meaningless while the entry is not counted.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  sram_resp_fifo_chk #(.RESP_DEPTH(RESP_DEPTH)) u_chk (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_push),
    .i_pop   (w_pop),
    .i_count (r_count)
  );

endmodule

// Protocol checker for the response FIFO: the credit scheme upstream must
// never push into a full FIFO without a simultaneous pop.
module sram_resp_fifo_chk #(
  parameter int RESP_DEPTH = 2,
  localparam int CNT_W     = $clog2(RESP_DEPTH + 1)
) (
  input logic             i_clk,
  input logic             i_rst_n,
  input logic             i_push,
  input logic             i_pop,
  input logic [CNT_W-1:0] i_count
);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !i_pop && (i_count == CNT_W'(RESP_DEPTH))));

endmodule

// File: rtl/sram_array_ctrl.sv
// Access controller in front of a single-port, 1-cycle-latency, bit-masked SRAM.
// Arbitrates a write channel and a read channel into one macro op per cycle,
// buffers read data in a response FIFO, and zero-fills the array after reset.
// Ports:
//   clock, reset                     clock, asynchronous active-low reset
//   w_valid/w_ready/w_addr/w_data/w_mask   write request channel
//   r_valid/r_ready/r_addr           read request channel
//   resp_valid/resp_ready/resp_data  read response channel
//   init_done                        zero-fill finished (sticky)
//   sram_*                           macro RW0 port
module sram_array_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int SETS       = SETS_DEFAULT,
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int INIT_EN    = 1,
  parameter int RESP_DEPTH = 2,
  localparam int CNT_W     = $clog2(RESP_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [WIDTH-1:0]  w_data,
  input  logic [WIDTH-1:0]  w_mask,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH-1:0]  resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [WIDTH-1:0]  sram_wmask,
  output logic [WIDTH-1:0]  sram_wdata,
  input  logic [WIDTH-1:0]  sram_rdata
);

  localparam ctrl_state_t RST_STATE = (INIT_EN != 0) ? INIT : RUN;

  ctrl_state_t       r_state;
  ctrl_state_t       w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              r_init_done;
  logic              r_prio_w;
  logic              r_inflight;

  logic [CNT_W-1:0]  w_fifo_count;
  logic [WIDTH-1:0]  w_fifo_head;
  logic              w_resp_valid;
  logic              w_pop;
  logic [CNT_W:0]    w_occ;
  logic              w_credit_ok;
  logic              w_w_elig;
  logic              w_r_elig;
  logic              w_w_ok;
  logic              w_r_ok;
  logic              w_grant_w;
  logic              w_grant_r;
  logic              w_cnt_last;

  assign w_resp_valid = (w_fifo_count != {CNT_W{1'b0}});
  assign w_pop        = w_resp_valid & resp_ready;
  // Outstanding reads after this cycle's pop; a read may issue only if it fits.
  assign w_occ        = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_inflight}
                      - {{CNT_W{1'b0}}, w_pop};
  assign w_credit_ok  = (w_occ < (CNT_W + 1)'(RESP_DEPTH));

  assign w_w_elig  = r_init_done & w_valid;
  assign w_r_elig  = r_init_done & r_valid & w_credit_ok;
  // Readiness: a channel loses only when the other is eligible and holds priority.
  assign w_w_ok    = r_init_done & (~w_r_elig | r_prio_w);
  assign w_r_ok    = r_init_done & w_credit_ok & (~w_valid | ~r_prio_w);
  assign w_grant_w = w_valid & w_w_ok;
  assign w_grant_r = r_valid & w_r_ok;
  assign w_cnt_last = (r_init_cnt == ADDR_W'(SETS - 1));

  assign resp_valid = w_resp_valid;
  assign resp_data  = w_resp_valid ? w_fifo_head : {WIDTH{1'b0}};
  assign init_done  = r_init_done;

  // Next-state logic: INIT walks the whole array once, then RUN forever.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    w_state_nxt = w_cnt_last ? RUN : INIT;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = RST_STATE;
    endcase
  end

  // Macro port and channel readiness; everything idles while reset is low.
  always_comb begin
    w_ready    = 1'b0;
    r_ready    = 1'b0;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = {ADDR_W{1'b0}};
    sram_wmask = {WIDTH{1'b0}};
    sram_wdata = {WIDTH{1'b0}};
    if (reset && (r_state == INIT)) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = r_init_cnt;
      sram_wmask = {WIDTH{1'b1}};
    end else if (reset && (r_state == RUN)) begin
      w_ready = w_w_ok;
      r_ready = w_r_ok;
      if (w_grant_w) begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = w_addr;
        sram_wmask = w_mask;
        sram_wdata = w_data;
      end else if (w_grant_r) begin
        sram_en    = 1'b1;
        sram_wmode = 1'b0;
        sram_addr  = r_addr;
      end else begin
        sram_en = 1'b0;
      end
    end else begin
      sram_en = 1'b0;
    end
  end

  // Control state: FSM, init counter, arbitration priority, read pipeline flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= RST_STATE;
      r_init_cnt  <= {ADDR_W{1'b0}};
      r_init_done <= 1'b0;
      r_prio_w    <= 1'b1;
      r_inflight  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      if (r_state == INIT) r_init_cnt <= r_init_cnt + ADDR_W'(1);
      r_init_done <= r_init_done | (r_state == RUN) | ((r_state == INIT) & w_cnt_last);
      // Priority only rotates when both channels actually competed.
      if (w_w_elig && w_r_elig) r_prio_w <= ~r_prio_w;
      r_inflight  <= w_grant_r;
    end
  end

  // Macro read data is valid the cycle after the read op; capture it then.
  sram_resp_fifo #(.WIDTH(WIDTH), .RESP_DEPTH(RESP_DEPTH)) u_resp_fifo (
    .i_clk       (clock),
    .i_rst_n     (reset),
    .i_push      (r_inflight),
    .i_push_data (sram_rdata),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_count     (w_fifo_count)
  );

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Randomised self-checking bench for sram_array_ctrl with a behavioural
// macro model and a transaction-level reference (memory array + response queue).
module tb_sram_array_ctrl;

  localparam int W = 216;
  localparam int A = 7;
  localparam int N = 128;
  localparam int DEPTH = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          w_valid = 1'b0, r_valid = 1'b0, resp_ready = 1'b0;
  logic          w_ready, r_ready, resp_valid, init_done;
  logic [A-1:0]  w_addr = '0, r_addr = '0;
  logic [W-1:0]  w_data = '0, w_mask = '0;
  logic [W-1:0]  resp_data;
  logic [A-1:0]  sram_addr;
  logic          sram_en, sram_wmode;
  logic [W-1:0]  sram_wmask, sram_wdata;
  logic [W-1:0]  sram_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  sram_array_ctrl dut (
    .clock(clock), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .init_done(init_done),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] rnd_word();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom();
    return t[W-1:0];
  endfunction

  // Macro model: 1-cycle read latency, bit-masked write; scrambled during reset.
  logic [W-1:0] mem [N];
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) mem[i] <= rnd_word();
    end else if (sram_en) begin
      if (sram_wmode) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
      else            sram_rdata <= mem[sram_addr];
    end
  end

  // Reference model state.
  typedef struct { logic [W-1:0] d; int issue; } resp_t;
  resp_t        q[$];
  logic [W-1:0] ref_mem [N];
  bit           m_prio_w;
  bit           m_done;
  int           m_init_cnt;
  int           cyc = 0;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit exp_rv, exp_pop, credit, w_el, r_el, exp_wg, exp_rg;
    resp_t e;
    @(negedge clock);
    check_val("init_done", init_done, m_done);
    if (!m_done) begin
      check_val("init_en", sram_en, 1'b1);
      check_val("init_wmode", sram_wmode, 1'b1);
      check_val("init_addr", sram_addr, m_init_cnt[A-1:0]);
      check_val("init_mask", sram_wmask, {W{1'b1}});
      check_val("init_data", sram_wdata, {W{1'b0}});
      check_val("init_wacc", w_valid & w_ready, 1'b0);
      check_val("init_racc", r_valid & r_ready, 1'b0);
      check_val("init_rv", resp_valid, 1'b0);
      @(posedge clock);
      m_init_cnt++;
      if (m_init_cnt == N) begin
        m_done = 1'b1;
        for (int i = 0; i < N; i++) ref_mem[i] = '0;
      end
    end else begin
      exp_rv  = (q.size() > 0) && (q[0].issue <= cyc - 2);
      check_val("resp_valid", resp_valid, exp_rv);
      if (exp_rv) check_val("resp_data", resp_data, q[0].d);
      exp_pop = exp_rv & resp_ready;
      credit  = (q.size() - int'(exp_pop)) < DEPTH;
      w_el    = w_valid;
      r_el    = r_valid & credit;
      exp_wg  = w_el & (!r_el | m_prio_w);
      exp_rg  = r_el & (!w_el | !m_prio_w);
      check_val("w_accept", w_valid & w_ready, exp_wg);
      check_val("r_accept", r_valid & r_ready, exp_rg);
      check_val("sram_en", sram_en, exp_wg | exp_rg);
      if (exp_wg) begin
        check_val("wr_wmode", sram_wmode, 1'b1);
        check_val("wr_addr", sram_addr, w_addr);
        check_val("wr_mask", sram_wmask, w_mask);
        check_val("wr_data", sram_wdata, w_data);
      end else if (exp_rg) begin
        check_val("rd_wmode", sram_wmode, 1'b0);
        check_val("rd_addr", sram_addr, r_addr);
      end
      @(posedge clock);
      if (exp_pop) void'(q.pop_front());
      if (exp_rg) begin
        e.d = ref_mem[r_addr];
        e.issue = cyc;
        q.push_back(e);
      end
      if (exp_wg) ref_mem[w_addr] = (ref_mem[w_addr] & ~w_mask) | (w_data & w_mask);
      if (w_el && r_el) m_prio_w = !m_prio_w;
    end
    cyc++;
    #1;
  endtask

  task automatic drv(input logic wv, input logic [A-1:0] wa, input logic [W-1:0] wd,
                     input logic [W-1:0] wm, input logic rv, input logic [A-1:0] ra,
                     input logic rr);
    w_valid = wv; w_addr = wa; w_data = wd; w_mask = wm;
    r_valid = rv; r_addr = ra; resp_ready = rr;
    step();
  endtask

  // Assert reset (mid-traffic allowed), check idle outputs, then rerun INIT.
  task automatic do_reset();
    reset = 1'b0;
    w_valid = 1'b1; r_valid = 1'b1; resp_ready = 1'b1;
    #1;
    check_val("rst_resp_valid_now", resp_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_val("rst_w_ready", w_ready, 1'b0);
      check_val("rst_r_ready", r_ready, 1'b0);
      check_val("rst_resp_valid", resp_valid, 1'b0);
      check_val("rst_init_done", init_done, 1'b0);
      check_val("rst_sram_en", sram_en, 1'b0);
      check_val("rst_resp_data", resp_data, {W{1'b0}});
      @(posedge clock);
      #1;
    end
    q.delete();
    m_prio_w = 1'b1; m_done = 1'b0; m_init_cnt = 0;
    reset = 1'b1;
    for (int i = 0; i < N; i++) step();
  endtask

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  initial begin
    // 1: reset, zero-fill, read of a filled location.
    do_reset();
    drv(1'b0, 7'd0, ZERO, ZERO, 1'b1, 7'd5, 1'b1);
    repeat (3) drv(1'b0, 7'd0, ZERO, ZERO, 1'b0, 7'd0, 1'b1);
    // 2: write then read back next cycle.
    drv(1'b1, 7'd3, {27{8'hA5}}, ONES, 1'b0, 7'd0, 1'b1);
    drv(1'b0, 7'd0, ZERO, ZERO, 1'b1, 7'd3, 1'b1);
    repeat (3) drv(1'b0, 7'd0, ZERO, ZERO, 1'b0, 7'd0, 1'b1);
    // 3: partial-mask write.
    drv(1'b1, 7'd9, ONES, ONES, 1'b0, 7'd0, 1'b1);
    drv(1'b1, 7'd9, ZERO, {{(W-8){1'b0}}, 8'hFF}, 1'b0, 7'd0, 1'b1);
    drv(1'b0, 7'd0, ZERO, ZERO, 1'b1, 7'd9, 1'b1);
    repeat (3) drv(1'b0, 7'd0, ZERO, ZERO, 1'b0, 7'd0, 1'b1);
    // 4: conflicts alternate; a lone write keeps priority.
    for (int i = 0; i < 4; i++) drv(1'b1, A'(20 + i), rnd_word(), ONES, 1'b1, 7'd3, 1'b1);
    drv(1'b1, 7'd30, rnd_word(), ONES, 1'b0, 7'd0, 1'b1);
    drv(1'b1, 7'd31, rnd_word(), ONES, 1'b1, 7'd9, 1'b1);
    repeat (3) drv(1'b0, 7'd0, ZERO, ZERO, 1'b0, 7'd0, 1'b1);
    // 5: backpressure limits outstanding reads, then full-rate drain.
    for (int i = 0; i < 5; i++) drv(1'b0, 7'd0, ZERO, ZERO, 1'b1, A'(i), 1'b0);
    for (int i = 0; i < 5; i++) drv(1'b0, 7'd0, ZERO, ZERO, 1'b1, A'(20 + i), 1'b1);
    repeat (3) drv(1'b0, 7'd0, ZERO, ZERO, 1'b0, 7'd0, 1'b1);
    // 6: read-then-write ordering, then reset with responses pending.
    drv(1'b1, 7'd7, {27{8'h11}}, ONES, 1'b0, 7'd0, 1'b1);
    drv(1'b0, 7'd0, ZERO, ZERO, 1'b1, 7'd7, 1'b1);
    drv(1'b1, 7'd7, {27{8'h22}}, ONES, 1'b0, 7'd0, 1'b1);
    drv(1'b0, 7'd0, ZERO, ZERO, 1'b1, 7'd7, 1'b1);
    repeat (3) drv(1'b0, 7'd0, ZERO, ZERO, 1'b0, 7'd0, 1'b1);
    drv(1'b0, 7'd0, ZERO, ZERO, 1'b1, 7'd7, 1'b0);
    drv(1'b0, 7'd0, ZERO, ZERO, 1'b1, 7'd3, 1'b0);
    repeat (2) drv(1'b0, 7'd0, ZERO, ZERO, 1'b0, 7'd0, 1'b0);
    check_val("pending_before_reset", resp_valid, 1'b1);
    do_reset();
    // Randomised traffic on a small address window to force collisions.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] m;
      case ($urandom_range(0, 2))
        0:       m = ONES;
        1:       m = {{(W-8){1'b0}}, 8'hFF};
        default: m = rnd_word();
      endcase
      drv(1'($urandom_range(0, 1)), A'($urandom_range(0, 15)), rnd_word(), m,
          1'($urandom_range(0, 1)), A'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    end
    repeat (4) drv(1'b0, 7'd0, ZERO, ZERO, 1'b0, 7'd0, 1'b1);
    check_val("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
